// File: rtl/mandelbrot_pkg.sv
// Shared types and IEEE-754 single-precision constants for the Mandelbrot iteration engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mandelbrot_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

  localparam logic [31:0] FP_ZERO    = 32'h00000000;
  localparam logic [31:0] FP_ONE     = 32'h3F800000;
  localparam logic [31:0] FP_TWO     = 32'h40000000;
  localparam logic [31:0] FP_NEG_TWO = 32'hC0000000;
  // |Z|^2 escape threshold; the point escapes only when strictly above it.
  localparam logic [31:0] FP_FOUR    = 32'h40800000;

endpackage

// File: rtl/mandelbrot_func.sv
// Combinational Mandelbrot step: (rr, ri) = Z^2 + C, unbounded = |Z|^2 > 4.
// Latency: 0 cycles (pure combinational; this is the engine's critical path).
// Backpressure: none. Ports: cr/ci (C), zr/zi (current Z) in; rr/ri, unbounded out.
module mandelbrot_func
  import mandelbrot_pkg::*;
(
  input  logic [31:0] cr,
  input  logic [31:0] ci,
  input  logic [31:0] zr,
  input  logic [31:0] zi,
  output logic [31:0] rr,
  output logic [31:0] ri,
  output logic        unbounded
);

  // Reduced IEEE-754 arithmetic: denormals flush to zero, results truncate,
  // overflow saturates to infinity. Exact for the small dyadic values the
  // iteration sees before escape; after escape the engine stops anyway.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       f;
    logic [31:0]       r;
    r = FP_ZERO;
    p = 48'd0;
    e = 10'sd0;
    f = 23'd0;
    if (a[30:23] != 8'd0 && b[30:23] != 8'd0) begin
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
      if (p[47]) begin
        f = p[46:24];
        e = e + 10'sd1;
      end else begin
        f = p[45:23];
      end
      if (e <= 10'sd0)        r = FP_ZERO;
      else if (e >= 10'sd255) r = {a[31] ^ b[31], 8'hFF, 23'd0};
      else                    r = {a[31] ^ b[31], e[7:0], f};
    end
    return r;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y, r;
    logic [7:0]        d;
    logic [26:0]       mx, my;
    logic [27:0]       s;
    logic signed [9:0] e;
    r = FP_ZERO;
    x = a; y = b; d = 8'd0; mx = 27'd0; my = 27'd0; s = 28'd0; e = 10'sd0;
    if (a[30:23] == 8'd0) begin
      r = b;
    end else if (b[30:23] == 8'd0) begin
      r = a;
    end else begin
      // x holds the larger magnitude so the result takes its sign.
      if (a[30:0] < b[30:0]) begin
        x = b; y = a;
      end
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      my = (d > 8'd26) ? 27'd0 : ({1'b1, y[22:0], 3'b000} >> d);
      e  = $signed({2'b00, x[30:23]});
      if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
      else                s = {1'b0, mx} - {1'b0, my};
      if (s != 28'd0) begin
        if (s[27]) begin
          s = s >> 1;
          e = e + 10'sd1;
        end
        for (int i = 0; i < 26; i++) begin
          if (!s[26]) begin
            s = s << 1;
            e = e - 10'sd1;
          end
        end
        if (e <= 10'sd0)        r = FP_ZERO;
        else if (e >= 10'sd255) r = {x[31], 8'hFF, 23'd0};
        else                    r = {x[31], e[7:0], s[25:3]};
      end
    end
    return r;
  endfunction

  logic [31:0] zr_sq, zi_sq, zr_zi, zr_zi_x2, mag_sq;

  always_comb begin
    zr_sq    = fp_mul(zr, zr);
    zi_sq    = fp_mul(zi, zi);
    zr_zi    = fp_mul(zr, zi);
    // Doubling is an exponent increment; zero must stay zero.
    zr_zi_x2 = (zr_zi[30:23] == 8'd0) ? zr_zi
                                      : {zr_zi[31], zr_zi[30:23] + 8'd1, zr_zi[22:0]};
    mag_sq   = fp_add(zr_sq, zi_sq);
    rr       = fp_add(fp_add(zr_sq, {~zi_sq[31], zi_sq[30:0]}), cr);
    ri       = fp_add(zr_zi_x2, ci);
    // mag_sq is never negative, so positive-float bit order matches numeric order.
    unbounded = (mag_sq > FP_FOUR);
  end

endmodule

// File: rtl/mandelbrot_iter_ctrl.sv
// Iteration engine: latches C on start, iterates Z <- Z^2 + C until escape or max_iter.
// Latency: start to done = iter_count + 2 clocks; one mandelbrot_func evaluation per clock.
// Backpressure: start is ignored while busy; results hold until the next accepted start.
// Ports: clk, rst_n (sync, active-low); start/cr/ci/max_iter in;
//        busy, done (1-cycle pulse), escaped, iter_count, zr_out, zi_out out.
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       cr,
  input  logic [31:0]       ci,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic              escaped,
  output logic [ITER_W-1:0] iter_count,
  output logic [31:0]       zr_out,
  output logic [31:0]       zi_out
);

  state_t            state;
  logic [31:0]       c_r, c_i, z_r, z_i;
  logic [31:0]       r_r, r_i;
  logic [ITER_W-1:0] lim, count;
  logic              unbounded;

  mandelbrot_func u_func (
    .cr        (c_r),
    .ci        (c_i),
    .zr        (z_r),
    .zi        (z_i),
    .rr        (r_r),
    .ri        (r_i),
    .unbounded (unbounded)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      c_r     <= FP_ZERO;
      c_i     <= FP_ZERO;
      z_r     <= FP_ZERO;
      z_i     <= FP_ZERO;
      lim     <= '0;
      count   <= '0;
      escaped <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            c_r     <= cr;
            c_i     <= ci;
            lim     <= max_iter;
            z_r     <= FP_ZERO;
            z_i     <= FP_ZERO;
            count   <= '0;
            escaped <= 1'b0;
            state   <= ST_ITER;
          end
        end
        ST_ITER: begin
          // Escape is judged on the current Z, and the limit is checked before
          // incrementing, so count never wraps even with max_iter all ones.
          if (unbounded) begin
            escaped <= 1'b1;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end else if (count == lim) begin
            escaped <= 1'b0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            z_r   <= r_r;
            z_i   <= r_i;
            count <= count + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy       = (state == ST_ITER);
  assign iter_count = count;
  assign zr_out     = z_r;
  assign zi_out     = z_i;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
module tb_mandelbrot_iter_ctrl;
  import mandelbrot_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] cr, ci;
  logic [7:0]  max_iter;
  logic        busy, done, escaped;
  logic [7:0]  iter_count;
  logic [31:0] zr_out, zi_out;

  int checks = 0;
  int errors = 0;

  mandelbrot_iter_ctrl #(.ITER_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cr         (cr),
    .ci         (ci),
    .max_iter   (max_iter),
    .busy       (busy),
    .done       (done),
    .escaped    (escaped),
    .iter_count (iter_count),
    .zr_out     (zr_out),
    .zi_out     (zi_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues start in the current cycle, then ticks until done is seen (bounded).
  // At 'poke' ticks after start, a stray start with C=2.0 is driven for one cycle.
  task automatic run_point(input logic [31:0] pr, input logic [31:0] pi,
                           input logic [7:0] pm, input int poke,
                           output int lat, output int bcy);
    start = 1'b1; cr = pr; ci = pi; max_iter = pm;
    lat = 0;
    bcy = 0;
    while (lat < 1000) begin
      tick();
      lat++;
      start = 1'b0;
      if (busy) bcy++;
      if (done) break;
      if (lat == poke) begin
        start = 1'b1;
        cr    = FP_TWO;
        ci    = FP_ZERO;
      end
    end
    start = 1'b0;
  endtask

  int  lat, bcy;
  logic seen_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; cr = '0; ci = '0; max_iter = '0;
    repeat (3) tick();
    check("rst_busy",    {31'd0, busy},       32'd0);
    check("rst_done",    {31'd0, done},       32'd0);
    check("rst_escaped", {31'd0, escaped},    32'd0);
    check("rst_count",   {24'd0, iter_count}, 32'd0);
    check("rst_zr",      zr_out,              32'd0);
    check("rst_zi",      zi_out,              32'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-run: C=0, limit 200, reset one cycle at cycle 10.
    start = 1'b1; cr = FP_ZERO; ci = FP_ZERO; max_iter = 8'd200;
    tick();
    start = 1'b0;
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy",    {31'd0, busy},       32'd0);
    check("mid_rst_done",    {31'd0, done},       32'd0);
    check("mid_rst_count",   {24'd0, iter_count}, 32'd0);
    check("mid_rst_escaped", {31'd0, escaped},    32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("mid_rst_no_done", {31'd0, seen_done}, 32'd0);

    // C = 1.0: Z = 0, 1, 2, 5 -> escapes after 3 updates.
    run_point(FP_ONE, FP_ZERO, 8'd50, -1, lat, bcy);
    check("c1_latency", 32'(lat),           32'd5);
    check("c1_escaped", {31'd0, escaped},   32'd1);
    check("c1_count",   {24'd0, iter_count}, 32'd3);
    check("c1_zr",      zr_out,             32'h40A00000);
    check("c1_zi",      zi_out,             32'h00000000);
    tick();
    check("c1_done_pulse", {31'd0, done},       32'd0);
    check("c1_hold_count", {24'd0, iter_count}, 32'd3);
    check("c1_hold_esc",   {31'd0, escaped},    32'd1);

    // C = 0: bounded, runs to the limit.
    run_point(FP_ZERO, FP_ZERO, 8'd20, -1, lat, bcy);
    check("c0_latency", 32'(lat),            32'd22);
    check("c0_busy",    32'(bcy),            32'd21);
    check("c0_escaped", {31'd0, escaped},    32'd0);
    check("c0_count",   {24'd0, iter_count}, 32'd20);
    check("c0_zr",      zr_out,              32'd0);
    check("c0_zi",      zi_out,              32'd0);
    tick();

    // C = -2.0: Z settles at 2 where |Z|^2 == 4 is still bounded.
    run_point(FP_NEG_TWO, FP_ZERO, 8'd10, -1, lat, bcy);
    check("cm2_latency", 32'(lat),            32'd12);
    check("cm2_escaped", {31'd0, escaped},    32'd0);
    check("cm2_count",   {24'd0, iter_count}, 32'd10);
    check("cm2_zr",      zr_out,              32'h40000000);
    check("cm2_zi",      zi_out,              32'h00000000);
    tick();

    // Stray start with C=2.0 while busy must be ignored.
    run_point(FP_NEG_TWO, FP_ZERO, 8'd10, 4, lat, bcy);
    check("poke_latency", 32'(lat),            32'd12);
    check("poke_escaped", {31'd0, escaped},    32'd0);
    check("poke_count",   {24'd0, iter_count}, 32'd10);
    check("poke_zr",      zr_out,              32'h40000000);
    tick();

    // max_iter = 0 terminates in the first ITER cycle.
    run_point(FP_ONE, FP_ZERO, 8'd0, -1, lat, bcy);
    check("m0_latency", 32'(lat),            32'd2);
    check("m0_escaped", {31'd0, escaped},    32'd0);
    check("m0_count",   {24'd0, iter_count}, 32'd0);
    check("m0_done",    {31'd0, done},       32'd1);

    // Start in the done cycle, C = i, full-range limit.
    run_point(FP_ZERO, FP_ONE, 8'd255, -1, lat, bcy);
    check("ci_latency", 32'(lat),            32'd257);
    check("ci_busy",    32'(bcy),            32'd256);
    check("ci_escaped", {31'd0, escaped},    32'd0);
    check("ci_count",   {24'd0, iter_count}, 32'd255);
    tick();
    check("ci_done_pulse", {31'd0, done}, 32'd0);
    check("ci_idle_busy",  {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mandelbrot_iter_ctrl.md
Name: mandelbrot_iter_ctrl

Overview:
- Sequential iteration engine that sits directly upstream of the combinational `mandelbrot_func` stage (R = Z^2 + C plus escape test) and drives it.
- Latches one point C, initialises Z = 0, and feeds Z back from R once per clock.
- Counts iterations and stops on escape (`unbounded`) or on reaching the iteration limit.
- Reports the iteration count and an escape flag to the pixel/host interface.

Parameters:
- ITER_W, 8, width of the iteration counter and of `max_iter`.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  begin computation for the point on `cr`/`ci`; honoured only in IDLE.
- cr  input  32  IEEE-754 single, real part of C; sampled on accepted start.
- ci  input  32  IEEE-754 single, imaginary part of C; sampled on accepted start.
- max_iter  input  ITER_W  iteration limit; sampled on accepted start.
- busy  output  1  high while in ITER.
- done  output  1  one-cycle pulse when a result becomes valid.
- escaped  output  1  1 = point left |Z| <= 2; 0 = limit reached.
- iter_count  output  ITER_W  number of Z updates performed before termination.
- zr_out  output  32  final Zr at termination.
- zi_out  output  32  final Zi at termination.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE.
  - busy, done, escaped, iter_count, zr_out, zi_out, and the internal C/Z/limit registers all go to 0.
  - Reset during ITER aborts the computation with no done pulse.
- States: IDLE and ITER.
- IDLE:
  - On start = 1, latch cr, ci and max_iter; set Z = 0 (32'h0 for both parts) and count = 0.
  - Clear escaped; next state is ITER.
  - start = 0 holds all outputs, so the previous result remains readable.
- ITER, evaluated once per cycle on the current Z, with priority in this order:
  - 1) `unbounded` = 1: escaped <= 1, next state IDLE, done pulses; count and Z stay unchanged.
  - 2) else if count == max_iter: escaped <= 0, next state IDLE, done pulses.
  - 3) else Z <= (Rr, Ri) and count <= count + 1; stay in ITER.
- Escape is therefore tested on Z before it is updated; iter_count equals the number of completed updates.
- done is high in the first IDLE cycle after ITER. In that same cycle, escaped, iter_count, zr_out and zi_out are already valid and remain stable until the next accepted start.
- busy = 1 exactly while state == ITER. start is ignored while busy.
- A start in the same cycle that done is high is accepted; the result outputs stay valid in that cycle.
- Latency from start to done is (iter_count + 2) clocks:
  - one cycle to enter ITER;
  - iter_count update cycles;
  - one terminating cycle.
- max_iter = 0: terminates in the first ITER cycle.
  - Z = 0 is bounded, so escaped = 0 and iter_count = 0.
- Counter cannot wrap: comparison against max_iter occurs before any increment. max_iter = 2^ITER_W - 1 is legal.
- One mandelbrot_func evaluation per clock: its combinational path is the critical path, and no pipelining is applied inside this block.

Decomposition:
- Shared package `mandelbrot_pkg`:
  - state enum (ST_IDLE, ST_ITER);
  - FP_ZERO = 32'h00000000;
  - common FP constants (1.0 = 32'h3F800000, 2.0 = 32'h40000000, -2.0 = 32'hC0000000) for use by the bench.
- One sub-module instance: `mandelbrot_func`, with inputs Cr/Ci from the latched C and Zr/Zi from the Z registers.
  - This block consumes its Rr, Ri and unbounded outputs.
- Counter, FSM and registers are inline; no other sub-modules.

Test Plan:
- Reset mid-run: start with C=0, max_iter=200, then drive rst_n=0 for one cycle at cycle 10 -> next cycle busy=0, done=0, iter_count=0, escaped=0; no done pulse afterwards.
- C = 1.0 (cr=32'h3F800000, ci=0), max_iter=50, start -> Z runs 0, 1, 2, 5; done with escaped=1, iter_count=3, zr_out=32'h40A00000; done exactly 5 clocks after start.
- C = 0, max_iter=20 -> escaped=0, iter_count=20, zr_out=zi_out=0, done 22 clocks after start; busy high for 21 cycles.
- C = -2.0 (cr=32'hC0000000), max_iter=10 -> Z runs 0, -2, 2, 2, ... which stays bounded at the ~4.0 threshold; escaped=0, iter_count=10, zr_out=32'h40000000.
- Boundaries: max_iter=0 with C=1.0 -> done 2 clocks after start, iter_count=0, escaped=0. Then assert start in the done cycle with C=0, i (ci=32'h3F800000), max_iter=255 -> accepted and busy next cycle; run ends with escaped=0, iter_count=255 (Z cycles 0, i, -1+i, -i, -1+i, ...).
- start pulsed during busy (C changed to 2.0 mid-run) -> ignored; result corresponds to the originally latched C.
